ula_exec: RTL and testbench

ULA_EXEC -- requirements
Module: ula_exec

---
 rtl/ula_exec.sv | 166 ++++++++++++++++
 tb/tb_ula_exec.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ula_exec.sv
// Small sequential ALU: one-hot op select, 1-cycle logic/arith ops, optional shift-add multiply.
// Latency: 2 edges from accept (non-MUL), WIDTH+1 edges for MUL; result held in DONE until out_ready.
// Backpressure: in_ready only in IDLE; DONE holds outputs stable while out_ready is low. Macro: ULA_MUL_EN.
module ula_exec #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         op_sel,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               ovf,
    output logic               zero,
    output logic               err,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      cnt;
    logic               legal;
    logic               mul_op;
    logic               exec_last;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;
    logic [2*WIDTH-1:0] alu_res;
    logic               alu_c;
    logic               alu_v;

`ifdef ULA_MUL_EN
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mul_sum;

    assign mul_op  = (op_q == 8'h80);
    assign legal   = $onehot(op_q);
    assign mul_sum = acc + (mplier[0] ? mcand : '0);
`else
    assign mul_op  = 1'b0;
    assign legal   = $onehot(op_q) && !op_q[7];
`endif

    // MUL finishes after WIDTH iterations, everything else after one EXEC cycle
    assign exec_last = !mul_op || (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = EXEC;
            EXEC:    if (exec_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Single-cycle ALU on captured operands; illegal selects yield all-zero result/flags
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        dif     = {1'b0, a_q} - {1'b0, b_q};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        if (legal) begin
            case (op_q)
                8'h01: begin
                    alu_res = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
                    alu_c   = sum[WIDTH];
                    alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
                end
                8'h02: begin
                    alu_res = {{WIDTH{1'b0}}, dif[WIDTH-1:0]};
                    alu_c   = dif[WIDTH];
                    alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1]);
                end
                8'h04: alu_res = {{WIDTH{1'b0}}, a_q & b_q};
                8'h08: alu_res = {{WIDTH{1'b0}}, a_q | b_q};
                8'h10: alu_res = {{WIDTH{1'b0}}, a_q ^ b_q};
                8'h20: alu_res = {{WIDTH{1'b0}}, ~a_q};
                8'h40: begin
                    alu_res = {{WIDTH{1'b0}}, a_q[WIDTH-2:0], 1'b0};
                    alu_c   = a_q[WIDTH-1];
                end
`ifdef ULA_MUL_EN
                8'h80: alu_res = mul_sum;
`endif
                default: alu_res = '0;
            endcase
        end
    end

    // Operand capture, multiply iteration and result/flag registers (written only on DONE entry)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            result <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            err    <= 1'b0;
`ifdef ULA_MUL_EN
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q   <= op_sel;
                    a_q    <= a;
                    b_q    <= b;
                    cnt    <= '0;
`ifdef ULA_MUL_EN
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, a};
                    mplier <= b;
`endif
                end
                EXEC: if (exec_last) begin
                    result <= alu_res;
                    carry  <= alu_c;
                    ovf    <= alu_v;
                    zero   <= (alu_res == '0);
                    err    <= !legal;
                end else begin
                    cnt    <= cnt + 1'b1;
`ifdef ULA_MUL_EN
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_exec.sv
// Self-checking bench for ula_exec (WIDTH = 4): directed vector table, random ops against a model,
// DONE backpressure hold and reset during a multi-cycle multiply.
module tb_ula_exec;

    localparam int W = 4;
`ifdef ULA_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   op_sel;
    logic [W-1:0] a_i, b_i;
    logic         in_valid, in_ready;
    logic [2*W-1:0] result;
    logic         carry, ovf, zero, err, out_valid, out_ready;

    int checks = 0;
    int errors = 0;

    ula_exec #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .op_sel(op_sel), .a(a_i), .b(b_i),
        .in_valid(in_valid), .in_ready(in_ready), .result(result),
        .carry(carry), .ovf(ovf), .zero(zero), .err(err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    name;
        logic [7:0] op;
        int       a, b;
        int       res, c, v, z, e, lat;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model built from the operation definitions with plain integer arithmetic
    task automatic model(input logic [7:0] op, input int a, input int b,
                         output int res, output int c, output int v,
                         output int z, output int e, output int lat);
        int n, sa, sb, sv;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(op[i]);
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        res = 0; c = 0; v = 0; e = 0; lat = 2;
        if (n != 1 || (op[7] && !MUL_EN)) begin
            e = 1;
        end else if (op[0]) begin
            res = (a + b) % 16; c = int'((a + b) > 15);
            sv = sa + sb; v = int'(sv > 7 || sv < -8);
        end else if (op[1]) begin
            res = (a - b + 16) % 16; c = int'(a < b);
            sv = sa - sb; v = int'(sv > 7 || sv < -8);
        end else if (op[2]) res = a & b;
        else if (op[3]) res = a | b;
        else if (op[4]) res = a ^ b;
        else if (op[5]) res = 15 - a;
        else if (op[6]) begin res = (a * 2) % 16; c = a / 8; end
        else begin res = a * b; lat = W + 1; end
        z = int'(res == 0);
    endtask

    // Issue one request, scramble inputs after capture, check latency/outputs, hold DONE, release
    task automatic run(input string nm, input logic [7:0] op, input int a, input int b,
                       input int er, input int ec, input int ev, input int ez,
                       input int ee, input int el, input int hold);
        int edges;
        @(negedge clk);
        chk({nm, ".in_ready"}, int'(in_ready), 1);
        op_sel = op; a_i = W'(a); b_i = W'(b); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op_sel = 8'($urandom); a_i = W'($urandom); b_i = W'($urandom);
        edges = 1;
        while (!out_valid && edges < 30) begin
            @(posedge clk); #1;
            edges++;
            op_sel = 8'($urandom); a_i = W'($urandom); b_i = W'($urandom);
        end
        chk({nm, ".latency"}, edges, el);
        chk({nm, ".result"}, int'(result), er);
        chk({nm, ".carry"}, int'(carry), ec);
        chk({nm, ".ovf"}, int'(ovf), ev);
        chk({nm, ".zero"}, int'(zero), ez);
        chk({nm, ".err"}, int'(err), ee);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; op_sel = 8'h01; a_i = W'($urandom); b_i = W'($urandom);
            @(posedge clk); #1;
            chk({nm, ".hold_valid"}, int'(out_valid), 1);
            chk({nm, ".hold_rdy"}, int'(in_ready), 0);
            chk({nm, ".hold_res"}, int'(result), er);
            chk({nm, ".hold_flags"}, int'({carry, ovf, zero, err}), (ec << 3) | (ev << 2) | (ez << 1) | ee);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, ".rel_valid"}, int'(out_valid), 0);
        chk({nm, ".rel_rdy"}, int'(in_ready), 1);
        if (hold > 0) begin
            @(posedge clk); #1;
            chk({nm, ".no_capture"}, int'(in_ready), 1);
        end
    endtask

    vec_t vt[$];

    initial begin
        int r, c, v, z, e, l;
        logic [7:0] op;
        int ra, rb;

        vt.push_back('{"add_wrap", 8'h01, 15, 1, 0, 1, 0, 1, 0, 2});
        vt.push_back('{"sub_borrow", 8'h02, 3, 5, 14, 1, 0, 0, 0, 2});
        vt.push_back('{"add_ovf", 8'h01, 7, 1, 8, 0, 1, 0, 0, 2});
        vt.push_back('{"sub_ovf", 8'h02, 8, 1, 7, 0, 1, 0, 0, 2});
        vt.push_back('{"and", 8'h04, 12, 10, 8, 0, 0, 0, 0, 2});
        vt.push_back('{"or", 8'h08, 12, 10, 14, 0, 0, 0, 0, 2});
        vt.push_back('{"xor", 8'h10, 12, 12, 0, 0, 0, 1, 0, 2});
        vt.push_back('{"not", 8'h20, 5, 0, 10, 0, 0, 0, 0, 2});
        vt.push_back('{"shl", 8'h40, 9, 0, 2, 1, 0, 0, 0, 2});
        vt.push_back('{"illegal_03", 8'h03, 9, 9, 0, 0, 0, 1, 1, 2});
        vt.push_back('{"illegal_00", 8'h00, 7, 1, 0, 0, 0, 1, 1, 2});
        if (MUL_EN) vt.push_back('{"mul_ff", 8'h80, 15, 15, 225, 0, 0, 0, 0, 5});
        else        vt.push_back('{"mul_off", 8'h80, 15, 15, 0, 0, 0, 1, 1, 2});

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_sel = '0; a_i = '0; b_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready", int'(in_ready), 1);
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.result", int'(result), 0);
        chk("reset.flags", int'({carry, ovf, zero, err}), 0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vt[i])
            run(vt[i].name, vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].c, vt[i].v,
                vt[i].z, vt[i].e, vt[i].lat, 0);

        // Consumer stalls DONE for 3 cycles while a new request is presented
        run("stall_add", 8'h01, 6, 5, 11, 0, 1, 0, 0, 2, 3);

        // Random ops, mostly one-hot with occasional arbitrary select
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 4) == 0) op = 8'($urandom);
            else                            op = 8'(1 << $urandom_range(0, 7));
            ra = $urandom_range(0, 15);
            rb = $urandom_range(0, 15);
            model(op, ra, rb, r, c, v, z, e, l);
            run("rand", op, ra, rb, r, c, v, z, e, l, $urandom_range(0, 1));
        end

        // Reset asserted during the second EXEC cycle of a multiply
        @(negedge clk);
        op_sel = 8'h80; a_i = 4'hF; b_i = 4'hF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mulrst.out_valid", int'(out_valid), 0);
        chk("mulrst.in_ready", int'(in_ready), 1);
        chk("mulrst.result", int'(result), 0);
        chk("mulrst.flags", int'({carry, ovf, zero, err}), 0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("mulrst.no_emit", int'(out_valid), 0);
        end
        run("post_rst_add", 8'h01, 2, 3, 5, 0, 0, 0, 0, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
